uart_multi_temp_tx: RTL and testbench

UART_MULTI_TEMP_TX -- requirements
Module: uart_multi_temp_tx

---
 rtl/uart_multi_temp_tx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_uart_multi_temp_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_multi_temp_tx.sv
// -----------------------------------------------------------------------------
// uart_multi_temp_tx
//
// Prints a multi-channel temperature report over an 8N1 UART line.
// One start request snapshots all channel temperatures (signed, x100) and the
// channel mask. Each enabled channel is then sent, in ascending index order, as
//   'C' <idx> ':' <sign> <INT_DIGITS integer digits> '.' <2 fraction digits> CR LF
// Values whose magnitude exceeds the printable range are shown as all '9's
// with their true sign, and flag the channel in ovf.
//
// Ports
//   clk      : system clock, everything on the rising edge
//   rst      : synchronous active-high reset
//   start    : one-cycle request to send one report (ignored while busy
//              or when ch_mask is zero)
//   ch_mask  : enabled channels, bit i = channel i
//   temp_bus : NUM_CH x 32-bit signed temperatures x100, channel i at [32*i +: 32]
//   tx       : UART line, LSB first, idle high
//   busy     : high while a report is in progress
//   done     : one-cycle pulse on the cycle busy falls
//   ovf      : per-channel saturation flags of the last report
// -----------------------------------------------------------------------------
module uart_multi_temp_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int NUM_CH     = 4,
    parameter int INT_DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic [32*NUM_CH-1:0] temp_bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CH-1:0]    ovf
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int ND       = INT_DIGITS + 2;   // decimal digits per channel
    localparam int NCHARS   = INT_DIGITS + 9;   // characters per channel line
    localparam logic [32:0] LIMIT = 33'(10**INT_DIGITS * 100 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    // The stop bit's last clock is spent in NEXT_CHAR, so STOP itself is one
    // clock short; this keeps the stop bit exactly BAUD_DIV clocks long and lets
    // the next start bit follow without a gap.
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(BAUD_DIV - 2);

    typedef enum logic [2:0] {
        IDLE, CONV, START, DATA, STOP, NEXT_CHAR
    } state_t;

    typedef logic [ND-1:0][3:0] digits_t;   // index 0 = most significant digit

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [3:0]            char_q, char_d;
    logic [2:0]            conv_q, conv_d;
    logic [2:0]            ch_q, ch_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [NUM_CH-1:0]     ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  tx_q, tx_d;
    logic [32*NUM_CH-1:0]  temp_q, temp_d;
    logic                  neg_q, neg_d;
    logic [19:0]           work_q, work_d;
    digits_t               digits_q, digits_d;

    logic [31:0]           cur_temp;
    logic signed [32:0]    val33;
    logic [32:0]           mag;
    logic [NUM_CH-1:0]     pend_rest;
    logic [7:0]            next_char;

    // Lowest set bit of a channel mask.
    function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // ASCII character at position pos of one channel's line.
    function automatic logic [7:0] char_at(input logic [3:0] pos, input logic [2:0] ch,
                                           input logic neg, input digits_t dig);
        logic [7:0] c;
        int         p;
        p = int'(pos);
        if (p == 0)                    c = "C";
        else if (p == 1)               c = 8'h30 + {5'd0, ch};
        else if (p == 2)               c = ":";
        else if (p == 3)               c = neg ? "-" : "+";
        else if (p < 4 + INT_DIGITS)   c = 8'h30 + {4'd0, dig[3'(p - 4)]};
        else if (p == 4 + INT_DIGITS)  c = ".";
        else if (p < 7 + INT_DIGITS)   c = 8'h30 + {4'd0, dig[3'(p - 5)]};
        else if (p == 7 + INT_DIGITS)  c = 8'h0D;
        else                           c = 8'h0A;
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        char_d   = char_q;
        conv_d   = conv_q;
        ch_d     = ch_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        temp_d   = temp_q;
        neg_d    = neg_q;
        work_d   = work_q;
        digits_d = digits_q;

        cur_temp  = temp_q[32*int'(ch_q) +: 32];
        // 33-bit magnitude so that -2^31 negates without overflow.
        val33     = {cur_temp[31], cur_temp};
        mag       = val33[32] ? 33'(-val33) : 33'(val33);
        pend_rest = pend_q & ~(NUM_CH'(1) << ch_q);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && (ch_mask != '0)) begin
                    temp_d  = temp_bus;
                    pend_d  = ch_mask;
                    ch_d    = first_ch(ch_mask);
                    ovf_d   = '0;
                    conv_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (conv_q == 3'd0) begin
                    neg_d = cur_temp[31];
                    // Loading the limit itself makes the extraction emit all '9's.
                    if (mag > LIMIT) begin
                        work_d = LIMIT[19:0];
                        ovf_d  = ovf_q | (NUM_CH'(1) << ch_q);
                    end else begin
                        work_d = mag[19:0];
                    end
                    conv_d = 3'd1;
                end else begin
                    // One decimal digit per clock, least significant first.
                    digits_d[3'(ND) - conv_q] = 4'(work_q % 20'd10);
                    work_d = work_q / 20'd10;
                    if (conv_q == 3'(ND)) begin
                        char_d  = '0;
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        conv_d = conv_q + 1'b1;
                    end
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_STOP) begin
                    cnt_d   = '0;
                    state_d = NEXT_CHAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT_CHAR: begin
                cnt_d = '0;
                if (char_q != 4'(NCHARS - 1)) begin
                    char_d  = char_q + 1'b1;
                    state_d = START;
                end else if (pend_rest != '0) begin
                    pend_d  = pend_rest;
                    ch_d    = first_ch(pend_rest);
                    conv_d  = '0;
                    state_d = CONV;
                end else begin
                    pend_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // tx is registered from next-state values so the line is glitch-free
        // and aligned with the state it belongs to.
        next_char = char_at(char_d, ch_d, neg_d, digits_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = next_char[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            conv_q  <= '0;
            ch_q    <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            conv_q  <= conv_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        temp_q   <= temp_d;
        neg_q    <= neg_d;
        work_q   <= work_d;
        digits_q <= digits_d;
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_multi_temp_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_multi_temp_tx
//
// Directed and randomized checks of uart_multi_temp_tx at 10 clocks per bit.
// A bit-level receiver decodes tx sample-by-sample and compares each
// character with a report string built by a printf-style reference model.
// -----------------------------------------------------------------------------
module tb_uart_multi_temp_tx;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [NUM_CH-1:0]    ch_mask = '0;
    logic [32*NUM_CH-1:0] temp_bus = '0;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic [NUM_CH-1:0]    ovf;

    int checks = 0;
    int failures = 0;

    uart_multi_temp_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .NUM_CH    (NUM_CH),
        .INT_DIGITS(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ch_mask (ch_mask),
        .temp_bus(temp_bus),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: one channel line from the formatting rules.
    function automatic string chan_str(input int ch, input logic [31:0] t, output bit sat);
        longint v, m;
        v   = longint'($signed(t));
        m   = (v < 0) ? -v : v;
        sat = (m > 99999);
        if (sat) m = 99999;
        return $sformatf("C%0d:%c%03d.%02d%c%c", ch, (v < 0) ? 8'd45 : 8'd43,
                         m / 100, m % 100, 8'd13, 8'd10);
    endfunction

    function automatic string report_str(input logic [NUM_CH-1:0] m,
                                         input logic [32*NUM_CH-1:0] bus,
                                         output logic [NUM_CH-1:0] eovf);
        string s;
        bit    sat;
        s    = "";
        eovf = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                s       = {s, chan_str(i, bus[32*i +: 32], sat)};
                eovf[i] = sat;
            end
        end
        return s;
    endfunction

    function automatic logic [31:0] rand_temp();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 199998)) - 32'd99999;
            2: case ($urandom_range(0, 7))
                   0: return 32'd99999;
                   1: return 32'd100000;
                   2: return -32'sd99999;
                   3: return -32'sd100000;
                   4: return 32'd0;
                   5: return 32'hFFFF_FFFF;
                   6: return 32'h7FFF_FFFF;
                   default: return 32'h8000_0000;
               endcase
            default: return 32'($urandom_range(0, 1000)) - 32'd500;
        endcase
    endfunction

    // Called on a falling edge; start is seen by exactly one rising edge.
    task automatic kick(input logic [NUM_CH-1:0] m, input logic [32*NUM_CH-1:0] bus);
        ch_mask  = m;
        temp_bus = bus;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_low(input int limit, input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < limit), 64'd1);
    endtask

    // Decodes one whole report; every one of the 10 samples of each bit must
    // agree, the first being the start of a fresh bit period.
    task automatic rx_report(input string want, input int disturb_at);
        logic [9:0] bits;
        logic [7:0] c;
        bit         steady;
        for (int k = 0; k < want.len(); k++) begin
            if (k == 0 || want[k-1] == 8'h0A) begin
                wait_low(40, "start_wait");
            end else begin
                @(negedge clk);
                chk("no_gap", 64'(tx), 64'd0);
            end
            steady = 1'b1;
            bits   = '0;
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < 10; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (s == 0) bits[b] = tx;
                    else if (tx !== bits[b]) steady = 1'b0;
                    if (k == disturb_at && b == 3) begin
                        if (s == 0) begin
                            temp_bus = {$urandom, $urandom, $urandom, $urandom};
                            start    = 1'b1;
                        end else if (s == 1) begin
                            start = 1'b0;
                            chk("busy_mid", 64'(busy), 64'd1);
                        end
                    end
                end
            end
            c = bits[8:1];
            chk($sformatf("frame%0d", k), 64'({steady, bits[0], bits[9]}), 64'b101);
            chk($sformatf("char%0d", k), 64'(c), 64'(want[k]));
        end
        @(negedge clk);
        chk("end_flags", 64'({busy, done, tx}), 64'b011);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic idle_window(input string tag, input int n);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) quiet = 1'b0;
        end
        chk(tag, 64'(quiet), 64'd1);
    endtask

    initial begin
        logic [32*NUM_CH-1:0] bus;
        logic [NUM_CH-1:0]    m;
        logic [NUM_CH-1:0]    eovf;
        string                want;

        repeat (3) @(negedge clk);
        chk("reset_state", 64'({tx, busy, done, ovf}), 64'({1'b1, 1'b0, 1'b0, 4'b0000}));
        rst = 1'b0;
        @(negedge clk);

        // Single channel, positive value.
        bus = '0;
        bus[31:0] = 32'd2537;
        kick(4'b0001, bus);
        chk("busy_after_start", 64'(busy), 64'd1);
        rx_report("C0:+025.37\015\012", -1);
        chk("ovf_r1", 64'(ovf), 64'd0);

        // Two sparse channels, small negative and -2^31 saturating.
        bus = '0;
        bus[63:32]  = -32'sd5;
        bus[127:96] = 32'h8000_0000;
        kick(4'b1010, bus);
        rx_report("C1:-000.05\015\012C3:-999.99\015\012", -1);
        chk("ovf_r2", 64'(ovf), 64'b1000);

        // Zero mask: request ignored.
        kick(4'b0000, {4{32'd1234}});
        idle_window("mask_zero_idle", 40);
        chk("mask_zero_ovf_kept", 64'(ovf), 64'b1000);

        // Inputs change and start is re-pulsed during the report.
        bus = {32'd7, 32'd0, 32'd99999, -32'sd12345};
        want = report_str(4'b0011, bus, eovf);
        kick(4'b0011, bus);
        ch_mask = 4'b1111;
        rx_report(want, 3);
        chk("ovf_snapshot", 64'(ovf), 64'(eovf));
        idle_window("no_queued_report", 30);

        // Reset in the middle of data bit 3.
        bus = '0;
        bus[95:64] = 32'h8000_0000;
        kick(4'b0100, bus);
        wait_low(40, "rst_start_wait");
        repeat (44) @(negedge clk);
        chk("ovf_before_rst", 64'(ovf), 64'b0100);
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_char", 64'({tx, busy, done, ovf}), 64'({1'b1, 1'b0, 1'b0, 4'b0000}));
        rst = 1'b0;
        bus = {32'd0, -32'sd99999, 32'd100000, 32'd42};
        want = report_str(4'b1101, bus, eovf);
        kick(4'b1101, bus);
        chk("busy_after_rst", 64'(busy), 64'd1);
        rx_report(want, -1);
        chk("ovf_after_rst", 64'(ovf), 64'(eovf));

        // Randomized reports; inputs are scrambled right after acceptance.
        for (int r = 0; r < 6; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_CH; i++) bus[32*i +: 32] = rand_temp();
            want = report_str(m, bus, eovf);
            kick(m, bus);
            temp_bus = {$urandom, $urandom, $urandom, $urandom};
            ch_mask  = 4'($urandom);
            rx_report(want, -1);
            chk($sformatf("ovf_rand%0d", r), 64'(ovf), 64'(eovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
